// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for clock_divider_prog: divisor load, enable/restart
// controls and the divided-clock / tick / status outputs.
interface clock_divider_prog_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en;
  logic             restart;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] div_active;
  logic             busy;
  logic             load_err;

  modport master (
    output en, restart, div_in, div_load,
    input  clk_out, tick, div_active, busy, load_err
  );

  modport slave (
    input  en, restart, div_in, div_load,
    output clk_out, tick, div_active, busy, load_err
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider with registered divided clock,
// one-cycle tick, glitch-free divisor changes at period boundaries and a sticky load error.
module clock_divider_prog #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input logic                  clk_in,
  input logic                  rst,
  clock_divider_prog_if.slave  bus
);

  localparam longint unsigned DIV_MAX = (64'd1 << WIDTH) - 64'd1;

  generate
    if (DEFAULT_DIV < 1 || longint'(DEFAULT_DIV) > DIV_MAX) begin : g_bad_default
      $error("clock_divider_prog: DEFAULT_DIV out of range 1..2^WIDTH-1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pend_q;
  logic             busy_q;
  logic             err_q;
  logic             clk_q;
  logic             tick_q;

  logic             last;
  logic             boundary;
  logic             apply;
  logic             load_ok;
  logic             load_bad;
  logic [WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] half_nxt;

  // Outputs are decoded from the post-edge count and divisor, so a divisor
  // swapped in at a boundary shapes the very first cycle of its own period.
  always_comb begin
    last     = 1'b0;
    boundary = 1'b0;
    apply    = 1'b0;
    load_ok  = 1'b0;
    load_bad = 1'b0;
    div_nxt  = div_q;
    cnt_nxt  = cnt_q;
    half_nxt = '0;

    last     = (cnt_q == (div_q - 1'b1));
    boundary = bus.en & (bus.restart | last);
    apply    = boundary & busy_q;
    div_nxt  = apply ? pend_q : div_q;
    cnt_nxt  = boundary ? '0 : (cnt_q + 1'b1);
    half_nxt = div_nxt - (div_nxt >> 1);
    load_ok  = bus.div_load & (bus.div_in != '0);
    load_bad = bus.div_load & (bus.div_in == '0);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q  <= DEF_DIV - 1'b1;
      div_q  <= DEF_DIV;
      pend_q <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      if (bus.en) begin
        cnt_q  <= cnt_nxt;
        div_q  <= div_nxt;
        tick_q <= (cnt_nxt == '0);
        clk_q  <= (cnt_nxt < half_nxt);
      end

      // A load coinciding with a boundary stays pending for the next one.
      if (load_ok) begin
        pend_q <= bus.div_in;
        busy_q <= 1'b1;
      end else if (apply) begin
        busy_q <= 1'b0;
      end

      if (load_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.clk_out    = clk_q;
  assign bus.tick       = tick_q;
  assign bus.div_active = div_q;
  assign bus.busy       = busy_q;
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: driver queues hand-computed expectations,
// a monitor pops and compares them after every clock (or async reset) edge.
module tb_clock_divider_prog;

  localparam int unsigned WIDTH = 16;

  typedef struct {
    int unsigned id;
    logic        t;
    logic        c;
    logic [15:0] d;
    logic        b;
    logic        e;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  clock_divider_prog_if #(.WIDTH(WIDTH)) bus ();

  clock_divider_prog #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(4)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  initial forever #5 clk_in = ~clk_in;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned vec_id = 0;

  task automatic push_exp(input logic xt, input logic xc, input logic [15:0] xd,
                          input logic xb, input logic xe);
    exp_t x;
    x.id = vec_id;
    x.t  = xt;
    x.c  = xc;
    x.d  = xd;
    x.b  = xb;
    x.e  = xe;
    exp_q.push_back(x);
    vec_id++;
  endtask

  // Drive one edge's inputs and queue the outputs expected right after that edge.
  task automatic vec(input logic v_en, input logic v_rs, input logic v_ld,
                     input logic [15:0] v_din,
                     input logic xt, input logic xc, input logic [15:0] xd,
                     input logic xb, input logic xe);
    @(negedge clk_in);
    bus.en       = v_en;
    bus.restart  = v_rs;
    bus.div_load = v_ld;
    bus.div_in   = v_din;
    push_exp(xt, xc, xd, xb, xe);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    bus.en       = 1'b0;
    bus.restart  = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    push_exp(1'b0, 1'b0, 16'd4, 1'b0, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic cmp1(input int unsigned id, input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s: got %b expected %b", id, nm, act, req);
    end
  endtask

  // Monitor: one expectation per clock edge or asynchronous reset assertion.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_in or posedge rst);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        cmp1(x.id, "tick",     bus.tick,     x.t);
        cmp1(x.id, "clk_out",  bus.clk_out,  x.c);
        cmp1(x.id, "busy",     bus.busy,     x.b);
        cmp1(x.id, "load_err", bus.load_err, x.e);
        checks++;
        if (bus.div_active !== x.d) begin
          errors++;
          $display("FAIL vec%0d div_active: got %0d expected %0d", x.id, bus.div_active, x.d);
        end
      end
    end
  end

  initial begin
    bus.en       = 1'b0;
    bus.restart  = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;

    // Held in reset
    vec(0,0,0,0, 0,0,4,0,0);
    rst = 1'b0;

    // D=4 from reset: first enabled edge wraps
    vec(1,0,0,0, 1,1,4,0,0);
    vec(1,0,0,0, 0,1,4,0,0);
    vec(1,0,0,0, 0,0,4,0,0);
    vec(1,0,0,0, 0,0,4,0,0);
    vec(1,0,0,0, 1,1,4,0,0);
    vec(1,0,0,0, 0,1,4,0,0);
    vec(1,0,0,0, 0,0,4,0,0);
    vec(1,0,0,0, 0,0,4,0,0);

    // Mid-period load of 3, applied at the wrap
    vec(1,0,0,0, 1,1,4,0,0);
    vec(1,0,1,3, 0,1,4,1,0);
    vec(1,0,0,0, 0,0,4,1,0);
    vec(1,0,0,0, 0,0,4,1,0);
    vec(1,0,0,0, 1,1,3,0,0);
    vec(1,0,0,0, 0,1,3,0,0);
    vec(1,0,0,0, 0,0,3,0,0);
    vec(1,0,0,0, 1,1,3,0,0);
    vec(1,0,0,0, 0,1,3,0,0);
    vec(1,0,0,0, 0,0,3,0,0);

    // Load 6 on a wrap edge (deferred), then 5 overrides it
    vec(1,0,1,6, 1,1,3,1,0);
    vec(1,0,1,5, 0,1,3,1,0);
    vec(1,0,0,0, 0,0,3,1,0);
    vec(1,0,0,0, 1,1,5,0,0);
    vec(1,0,0,0, 0,1,5,0,0);
    vec(1,0,0,0, 0,1,5,0,0);
    vec(1,0,0,0, 0,0,5,0,0);
    vec(1,0,0,0, 0,0,5,0,0);
    vec(1,0,0,0, 1,1,5,0,0);

    // Zero loads flag the error and leave pending/busy alone
    vec(1,0,1,0, 0,1,5,0,1);
    vec(1,0,1,4, 0,1,5,1,1);
    vec(1,0,1,0, 0,0,5,1,1);
    vec(1,0,0,0, 0,0,5,1,1);
    vec(1,0,0,0, 1,1,4,0,1);

    // Freeze 7 cycles at cnt=2 (restart while frozen is ignored)
    vec(1,0,0,0, 0,1,4,0,1);
    vec(1,0,0,0, 0,0,4,0,1);
    for (int i = 0; i < 7; i++) begin
      vec(0, (i == 3) ? 1'b1 : 1'b0, 0, 0, 0,0,4,0,1);
    end
    vec(1,0,0,0, 0,0,4,0,1);
    vec(1,0,0,0, 1,1,4,0,1);

    // Load 2, then restart at cnt=2 applies it immediately
    vec(1,0,1,2, 0,1,4,1,1);
    vec(1,0,0,0, 0,0,4,1,1);
    vec(1,1,0,0, 1,1,2,0,1);
    vec(1,0,0,0, 0,0,2,0,1);
    vec(1,0,0,0, 1,1,2,0,1);
    // Freeze on a tick cycle: tick stays high
    vec(0,0,0,0, 1,1,2,0,1);
    vec(0,0,0,0, 1,1,2,0,1);
    vec(1,0,0,0, 0,0,2,0,1);

    // D=1: tick and clk_out constantly high
    vec(1,0,1,1, 1,1,2,1,1);
    vec(1,0,0,0, 0,0,2,1,1);
    vec(1,0,0,0, 1,1,1,0,1);
    vec(1,0,0,0, 1,1,1,0,1);
    vec(1,0,0,0, 1,1,1,0,1);

    // Pending load then async reset: everything back to defaults
    vec(1,0,1,3, 1,1,1,1,1);
    do_reset();
    vec(1,0,0,0, 1,1,4,0,0);

    // Maximum divisor via restart
    vec(1,0,1,16'hFFFF, 0,1,4,1,0);
    vec(1,1,0,0,        1,1,16'hFFFF,0,0);
    vec(1,0,0,0,        0,1,16'hFFFF,0,0);

    @(negedge clk_in);
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.restart  = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_in);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Runtime-programmable integer clock divider; successor to the fixed, parameter-only divider used to derive the NCO sample and update clocks.
- Adds:
  - a WIDTH-generic divisor loaded at run time, applied glitch-free at period boundaries
  - a one-cycle tick (clock-enable) output
  - odd-divisor support, enable/hold, synchronous restart, and an error flag
- Sits between the system clock and the NCO phase accumulator / DAC interface logic.

Parameters:
- WIDTH, 16, bit width of the divisor and internal counter.
- DEFAULT_DIV, 4, divisor in force after reset; legal range 1..2^WIDTH-1, otherwise elaboration error.

Ports:
- clk_in  input  1  sole clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; 0 freezes counter and all outputs.
- restart  input  1  synchronous period restart, acts only when en=1.
- div_in  input  WIDTH  new divisor value.
- div_load  input  1  one-cycle strobe; samples div_in.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse on the first clk_in cycle of every output period, registered.
- div_active  output  WIDTH  divisor currently in force.
- busy  output  1  a loaded divisor is pending (not yet applied).
- load_err  output  1  sticky; set when div_load is seen with div_in=0.

Behaviour:
- Reset values (async, immediate):
  - cnt = DEFAULT_DIV-1; div_active = DEFAULT_DIV; pending register = 0.
  - clk_out = 0, tick = 0, busy = 0, load_err = 0.
- Period: D = div_active clk_in cycles; cnt runs 0..D-1 and then wraps.
- Per rising edge with en=1:
  - If restart=1 or cnt==D-1 (wrap):
    - next cnt = 0.
    - If busy, div_active <= pending and busy <= 0.
  - Otherwise next cnt = cnt+1.
- Outputs are registered decodes of the next state:
  - tick <= (next cnt == 0).
  - clk_out <= (next cnt < H), where H = D_next - (D_next >> 1), i.e. high for ceil(D/2) cycles and low for floor(D/2).
  - D_next is the divisor in force after that edge.
- Consequence of reset cnt=D-1: the first enabled edge after reset is a wrap, giving tick=1 and clk_out=1 one cycle later. Latency from first enable to first tick = 1 clk_in cycle.
- D=1: tick=1 and clk_out=1 on every enabled cycle (pass-through enable, constant-high clock).
- D=2: 50% duty square wave at clk_in/2. Odd D (e.g. 3) gives high 2 / low 1; duty is not 50% by design.
- en=0: cnt, clk_out and tick hold their values. tick therefore stays high if frozen on a tick cycle; consumers must qualify tick with en.
- div_load rules:
  - div_load=1 with div_in != 0: pending <= div_in and busy <= 1, regardless of en.
  - A load on the same edge as a wrap/restart is NOT applied on that edge; it becomes pending and is applied at the next boundary.
  - Multiple loads before the boundary: last one wins.
- div_load=1 with div_in == 0: pending and busy are unchanged; load_err <= 1. load_err is cleared only by rst.
- restart with busy=1: the pending divisor is applied immediately, giving a new period with the new D starting next cycle.
- restart with en=0: ignored.
- Counter width: cnt is WIDTH bits and never exceeds D-1. Comparisons are unsigned, with no overflow for D = 2^WIDTH-1.
- Mid-operation rst: all state returns to the reset values asynchronously. The pending load is discarded.

Test Plan:
- Reset then en=1, DEFAULT_DIV=4 -> tick high at cycles 1,5,9,...; clk_out 1,1,0,0 repeating; div_active=4, busy=0.
- div_load with div_in=3 at cycle 2 (mid-period) -> busy=1 until the wrap edge at cycle 4, then tick at 5, 8, 11; clk_out 1,1,0 repeating; div_active=3.
- Two loads (6 then 5) within one period, then wrap -> div_active=5 and 6 is never used; clk_out high 3 / low 2.
- div_load with div_in=0 -> load_err=1 and stays 1; div_active and busy unchanged; output period unaffected.
- en=0 for 7 cycles mid-period with D=4 -> clk_out, tick and cnt frozen; on resume the remaining period length equals what was left, so no short or long pulse.
- restart at cnt=2 with a pending load of 2 -> tick next cycle; clk_out toggles every cycle from there; rst asserted mid-period -> clk_out=0, tick=0, div_active=DEFAULT_DIV immediately (asynchronously).
